board_move_sched: RTL and testbench

Board-level scheduler that sequences the eight column move-generator units and drains their move lists into one output stream. After `start` it pulses the column reset, waits for each column's done flag, and drains completed columns one move at a time, lowest index first. Each move is presented downstream on a valid/ready handshake. It stops when every column has returned its end marker. The block sits between the column array and the search/evaluation logic that consumes legal-move candidates.

---
 rtl/board_move_sched.sv | 163 ++++++++++++++++
 tb/tb_board_move_sched.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_move_sched.sv
// board_move_sched: sequences the column move-generator units and drains their
// move lists, lowest column index first, into one valid/ready output stream.
module board_move_sched #(
    parameter int unsigned NCOL  = 8,
    parameter int unsigned MW    = 19,
    parameter int unsigned MAXMV = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NCOL-1:0]      col_done,
    input  logic [NCOL*MW-1:0]   col_move,
    output logic [NCOL-1:0]      col_rden,
    output logic                 col_reset,
    output logic [MW-1:0]        out_move,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           move_count,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow_err
);

    localparam int unsigned PW      = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int unsigned CW      = $clog2(MAXMV) + 1;
    localparam int unsigned END_BIT = MW - 1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SCAN,
        READ,
        CAPT,
        EMIT,
        DONE
    } state_t;

    state_t          state;
    logic [NCOL-1:0] drained;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   col_cnt;
    logic            force_drain;

    logic            sel_found;
    logic [PW-1:0]   sel_idx;
    logic [MW-1:0]   cur_word;
    logic            at_limit;

    // Lowest-index column that has finished generating and is not yet drained
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int c = int'(NCOL) - 1; c >= 0; c--) begin
            if (col_done[c] && !drained[c]) begin
                sel_found = 1'b1;
                sel_idx   = PW'(c);
            end
        end
    end

    // Head word of the column currently being drained
    always_comb begin
        cur_word = '0;
        for (int c = 0; c < int'(NCOL); c++) begin
            if (ptr == PW'(c)) begin
                cur_word = col_move[c*MW +: MW];
            end
        end
    end

    // The word being captured is the last one this column is allowed to emit
    always_comb begin
        at_limit = (col_cnt == CW'(MAXMV - 1));
    end

    // Scheduler FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            drained      <= '0;
            ptr          <= '0;
            col_cnt      <= '0;
            force_drain  <= 1'b0;
            col_rden     <= '0;
            col_reset    <= 1'b0;
            out_move     <= '0;
            out_valid    <= 1'b0;
            move_count   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            col_rden  <= '0;
            col_reset <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= LAUNCH;
                        col_reset    <= 1'b1;
                        drained      <= '0;
                        move_count   <= '0;
                        overflow_err <= 1'b0;
                        col_cnt      <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                    end
                end
                LAUNCH: begin
                    state <= SCAN;
                end
                SCAN: begin
                    if (sel_found) begin
                        ptr      <= sel_idx;
                        col_cnt  <= '0;
                        col_rden <= NCOL'(1) << sel_idx;
                        state    <= READ;
                    end else if (&drained) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                READ: begin
                    state <= CAPT;
                end
                CAPT: begin
                    if (cur_word[END_BIT]) begin
                        drained[ptr] <= 1'b1;
                        state        <= SCAN;
                    end else begin
                        out_move    <= cur_word;
                        out_valid   <= 1'b1;
                        force_drain <= at_limit;
                        if (at_limit) begin
                            overflow_err <= 1'b1;
                            drained[ptr] <= 1'b1;
                        end
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        col_cnt   <= col_cnt + CW'(1);
                        if (move_count != 8'hFF) begin
                            move_count <= move_count + 8'd1;
                        end
                        if (force_drain) begin
                            state <= SCAN;
                        end else begin
                            col_rden <= NCOL'(1) << ptr;
                            state    <= READ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_move_sched.sv
// Testbench for board_move_sched: behavioural column model, scoreboard of
// expected output words, and pass-level checks of counters and flags.
module tb_board_move_sched;

    localparam int unsigned NCOL  = 8;
    localparam int unsigned MW    = 19;
    localparam int unsigned MAXMV = 32;
    localparam int          MAXI  = int'(MAXMV);
    localparam logic [MW-1:0] END_W = 19'h40000;

    logic                clk          = 1'b0;
    logic                reset        = 1'b1;
    logic                start        = 1'b0;
    logic [NCOL-1:0]     col_done     = '1;
    logic [NCOL*MW-1:0]  col_move     = '0;
    logic [NCOL-1:0]     col_rden;
    logic                col_reset;
    logic [MW-1:0]       out_move;
    logic                out_valid;
    logic                out_ready    = 1'b0;
    logic [7:0]          move_count;
    logic                busy;
    logic                done;
    logic                overflow_err;

    board_move_sched #(.NCOL(NCOL), .MW(MW), .MAXMV(MAXMV)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .col_done     (col_done),
        .col_move     (col_move),
        .col_rden     (col_rden),
        .col_reset    (col_reset),
        .out_move     (out_move),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .move_count   (move_count),
        .busy         (busy),
        .done         (done),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Column contents for the current pass (written only by setup tasks)
    logic [MW-1:0] colq [NCOL][$];
    int            gen = 0;
    // Scoreboard: expected words, consumed by the monitor through exp_rd
    logic [MW-1:0] exp_mem [$];
    int            flush_to = 0;
    int            exp_rd = 0;
    int            exp_total;
    int            exp_rden;
    logic          exp_ovf;
    // Observed event counters (written only by monitors)
    int            rden_cnt = 0;
    int            creset_cnt = 0;
    int            acc_cnt = 0;
    int            c5_end_cnt = 0;
    int            order_base = 0;
    logic          order_chk = 1'b0;
    int            ready_mode = 0;
    int            rden_base, creset_base, acc_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Downstream ready: 0 = stalled, 1 = always ready, otherwise random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Column units: a read enable returns the next stored word, or an end
    // marker once the column's list is exhausted
    int rd_idx [NCOL];
    int seen_gen = 0;
    always @(negedge clk) begin
        logic [MW-1:0] w;
        if (gen != seen_gen) begin
            seen_gen = gen;
            for (int c = 0; c < int'(NCOL); c++) rd_idx[c] = 0;
        end
        if (col_rden != '0) begin
            rden_cnt++;
            check("rden_onehot", 32'($onehot(col_rden)), 32'd1);
        end
        for (int c = 0; c < int'(NCOL); c++) begin
            if (col_rden[c]) begin
                if (rd_idx[c] < colq[c].size()) w = colq[c][rd_idx[c]];
                else w = END_W;
                rd_idx[c]++;
                col_move[c*MW +: MW] = w;
                if (c == 5 && w[MW-1]) c5_end_cnt++;
                if (c == 2 && order_chk)
                    check("order_c2_after_c5", 32'(c5_end_cnt > order_base), 32'd1);
            end
        end
        if (col_reset) creset_cnt++;
    end

    // Output monitor: every accepted beat is compared with the scoreboard head
    always @(negedge clk) begin
        if (exp_rd < flush_to) exp_rd = flush_to;
        if (out_valid && out_ready && !reset) begin
            acc_cnt++;
            if (exp_rd >= exp_mem.size()) begin
                checks++;
                errors++;
                $display("FAIL out_extra: got %0h expected none", out_move);
            end else begin
                check("out_move", 32'(out_move), 32'(exp_mem[exp_rd]));
                exp_rd++;
            end
        end
    end

    task automatic clear_cols();
        gen++;
        for (int c = 0; c < int'(NCOL); c++) colq[c].delete();
        exp_total = 0;
        exp_rden  = 0;
        exp_ovf   = 1'b0;
        flush_to  = exp_mem.size();
    endtask

    task automatic fill_col(input int c, input int n, input bit has_end);
        for (int i = 0; i < n; i++) colq[c].push_back({1'b0, 18'($urandom)});
        if (has_end) colq[c].push_back(END_W);
    endtask

    // Reference: a column yields its words up to the end marker, capped at
    // MAXMV; reaching the cap flags overflow and skips the end marker read
    task automatic expect_col(input int c);
        int n;
        logic [MW-1:0] w;
        n = 0;
        while (n < colq[c].size()) begin
            w = colq[c][n];
            if (w[MW-1]) break;
            n++;
        end
        if (n >= MAXI) begin
            for (int i = 0; i < MAXI; i++) exp_mem.push_back(colq[c][i]);
            exp_total += MAXI;
            exp_rden  += MAXI;
            exp_ovf    = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) exp_mem.push_back(colq[c][i]);
            exp_total += n;
            exp_rden  += n + 1;
        end
    endtask

    task automatic expect_all();
        for (int c = 0; c < int'(NCOL); c++) expect_col(c);
    endtask

    task automatic start_pass();
        rden_base   = rden_cnt;
        creset_base = creset_cnt;
        acc_base    = acc_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int timeout, input bit poke_start);
        bit ok;
        ok = 1'b0;
        for (int cyc = 0; cyc < timeout; cyc++) begin
            @(negedge clk);
            if (poke_start) begin
                if (cyc == 10) start = 1'b1;
                if (cyc == 11) start = 1'b0;
            end
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        #1;
        if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_move_count"}, 32'(move_count), 32'((exp_total > 255) ? 255 : exp_total));
        check({name, "_overflow"}, 32'(overflow_err), 32'(exp_ovf));
        check({name, "_rden_pulses"}, 32'(rden_cnt - rden_base), 32'(exp_rden));
        check({name, "_col_reset_pulses"}, 32'(creset_cnt - creset_base), 32'd1);
        check({name, "_accepted"}, 32'(acc_cnt - acc_base), 32'(exp_total));
        check({name, "_pending"}, 32'(exp_mem.size() - exp_rd), 32'd0);
    endtask

    task automatic wait_valid(input string name, input int timeout);
        bit ok;
        ok = 1'b0;
        for (int cyc = 0; cyc < timeout; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_valid_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_out_move"}, 32'(out_move), 32'd0);
        check({name, "_col_rden"}, 32'(col_rden), 32'd0);
        check({name, "_col_reset"}, 32'(col_reset), 32'd0);
        check({name, "_move_count"}, 32'(move_count), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_overflow"}, 32'(overflow_err), 32'd0);
    endtask

    initial begin
        logic [MW-1:0] held;
        int base;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Basic pass: column 0 has three moves, the rest end immediately
        clear_cols();
        fill_col(0, 3, 1'b1);
        for (int c = 1; c < int'(NCOL); c++) fill_col(c, 0, 1'b1);
        expect_all();
        col_done   = '1;
        ready_mode = 1;
        start_pass();
        wait_done("basic", 200, 1'b0);

        // Backpressure on the first beat of a two-move column
        clear_cols();
        for (int c = 0; c < int'(NCOL); c++) fill_col(c, (c == 4) ? 2 : 0, 1'b1);
        expect_all();
        ready_mode = 0;
        start_pass();
        wait_valid("bp", 100);
        held = out_move;
        base = rden_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_move_stable", 32'(out_move), 32'(held));
            check("bp_no_rden", 32'(rden_cnt), 32'(base));
        end
        ready_mode = 1;
        wait_done("bp", 200, 1'b0);

        // Late done: column 2 becomes ready while column 5 is draining
        clear_cols();
        for (int c = 0; c < int'(NCOL); c++) fill_col(c, (c == 5) ? 6 : (c == 2) ? 4 : 0, 1'b1);
        expect_col(5);
        expect_col(2);
        for (int c = 0; c < int'(NCOL); c++) if (c != 5 && c != 2) expect_col(c);
        col_done   = 8'b0010_0000;
        order_base = c5_end_cnt;
        order_chk  = 1'b1;
        start_pass();
        for (int cyc = 0; cyc < 100 && (acc_cnt - acc_base) < 2; cyc++) @(negedge clk);
        col_done[2] = 1'b1;
        repeat (5) @(negedge clk);
        col_done = '1;
        wait_done("late", 300, 1'b0);
        order_chk = 1'b0;

        // Missing end marker on column 3
        clear_cols();
        for (int c = 0; c < int'(NCOL); c++) fill_col(c, (c == 3) ? 40 : 0, c != 3);
        expect_all();
        start_pass();
        wait_done("noend", 500, 1'b0);

        // Reset while a beat is waiting for acceptance
        clear_cols();
        for (int c = 0; c < int'(NCOL); c++) fill_col(c, (c == 1) ? 3 : 0, 1'b1);
        ready_mode = 0;
        start_pass();
        wait_valid("rst", 100);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        base = rden_cnt;
        repeat (3) @(negedge clk);
        check("midreset_no_rden", 32'(rden_cnt), 32'(base));
        clear_cols();
        for (int c = 0; c < int'(NCOL); c++) fill_col(c, (c == 1) ? 3 : 0, 1'b1);
        expect_all();
        ready_mode = 1;
        start_pass();
        wait_done("after_reset", 200, 1'b0);

        // Saturation: every column overflows, 256 beats in total
        clear_cols();
        for (int c = 0; c < int'(NCOL); c++) fill_col(c, 40, 1'b0);
        expect_all();
        ready_mode = 2;
        start_pass();
        wait_done("saturate", 3000, 1'b0);

        // Randomised passes with random backpressure and a stray start
        for (int p = 0; p < 4; p++) begin
            clear_cols();
            for (int c = 0; c < int'(NCOL); c++)
                fill_col(c, int'($urandom_range(0, 36)), $urandom_range(0, 3) != 0);
            expect_all();
            ready_mode = 2;
            start_pass();
            wait_done("random", 4000, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
